fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 16-bit pipelined processor. Holds the program counter and drives the instruction-memory address. Assembles one- and two-word instructions and presents them, with a valid flag, to the falling-edge IF/ID pipeline register directly downstream. Honours stall and flush requests from the hazard/branch logic and boots from a reset vector stored in memory.

## Interface
- DATA_W, 16, instruction word, immediate and PC width
- RESET_VEC, 16'h0000, memory address holding the boot PC
- INT_VEC, 16'h0001, memory address holding the interrupt handler PC (used only with FETCH_INT_EN)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; asynchronous, active-high
- STALL  in  1  hold all fetch state this cycle
- FLUSH  in  1  redirect: discard the in-flight fetch and load BR_TARGET
- BR_TARGET  in  DATA_W  redirect address
- IMEM_ADDR  out  DATA_W  instruction memory address (combinational from state/PC)
- IMEM_DATA  in  DATA_W  instruction memory read data (asynchronous read, same cycle)
- IR_OUT  out  DATA_W  fetched instruction word (registered)
- IMM_OUT  out  DATA_W  second word of a two-word instruction, else 0 (registered)
- PC_OUT  out  DATA_W  address following the fetched instruction (registered)
- VALID  out  1  IR_OUT/IMM_OUT/PC_OUT form a complete instruction (registered)
- INT  in  1  interrupt request level (FETCH_INT_EN only)
- INT_ACK  out  1  one-cycle pulse when the interrupt is taken (FETCH_INT_EN only)
- EPC  out  DATA_W  PC saved when the interrupt is taken (FETCH_INT_EN only)

## Operation
- States: BOOT, FETCH, IMM, plus INTV with FETCH_INT_EN.
- Reset: state=BOOT; PC, IR_OUT, IMM_OUT, PC_OUT, EPC=0; VALID=0; INT_ACK=0.
- BOOT: IMEM_ADDR=RESET_VEC. PC<=IMEM_DATA; next state FETCH; VALID=0. Ignores STALL and FLUSH.
- FETCH: IMEM_ADDR=PC. IR_OUT<=IMEM_DATA; PC<=PC+1; PC_OUT<=PC+1.
  - If IMEM_DATA[15:14]==2'b11 (two-word opcode): VALID<=0 and next state IMM.
  - Otherwise: IMM_OUT<=0, VALID<=1, stay in FETCH.
- IMM: IMEM_ADDR=PC. IMM_OUT<=IMEM_DATA; PC<=PC+1; PC_OUT<=PC+1; VALID<=1; next state FETCH.
- Priority in FETCH and IMM is FLUSH > STALL > normal.
  - FLUSH: PC<=BR_TARGET, VALID<=0, next state FETCH. Any half-assembled two-word instruction is discarded.
  - STALL: every register holds, including VALID. IMEM_ADDR is unchanged.
- PC arithmetic is modulo 2^DATA_W: 16'hFFFF+1 = 16'h0000, with no flag raised.

## Timing
- IMEM_ADDR to capture takes 1 cycle. A one-word instruction reaches VALID=1 one rising edge after its address is presented. A two-word instruction takes two edges.
- Outputs settle after the rising edge and are stable for the downstream falling-edge capture in the same cycle.
- After RST deasserts: BOOT on the 1st edge, first FETCH capture on the 2nd edge. The earliest VALID=1 is after the 2nd edge.
- RST asserted mid-operation (including in IMM or INTV) returns immediately and asynchronously to the reset values.
- FLUSH and STALL in the same cycle: FLUSH wins.

## Configuration
- FETCH_INT_EN defined:
  - INT, INT_ACK, EPC and state INTV exist.
  - INT is sampled only in FETCH when neither FLUSH nor STALL is asserted, so interrupts are never taken between the two words of an instruction.
  - When taken: that cycle's fetch is suppressed; EPC<=PC, VALID<=0, next state INTV.
  - INTV: IMEM_ADDR=INT_VEC; PC<=IMEM_DATA; INT_ACK=1 for this cycle only; next state FETCH. FLUSH and STALL are ignored in INTV.
- FETCH_INT_EN undefined: those ports and INTV are absent, and the block behaves as the base three-state machine.

## Test plan
- Reset/boot: mem[0]=16'h0010, mem[0x10]=16'h1234 -> after 2 edges IR_OUT=1234, PC_OUT=0011, VALID=1.
- Two-word: mem[0x10]=16'hC005, mem[0x11]=16'hABCD -> VALID=0 after the 1st fetch edge, then IR_OUT=C005, IMM_OUT=ABCD, PC_OUT=0012, VALID=1.
- Stall: STALL=1 for 3 cycles mid-stream -> IMEM_ADDR and all outputs unchanged, then the sequence resumes with no word skipped or repeated.
- Flush in IMM: FLUSH=1 with BR_TARGET=16'h0040 while in IMM, STALL=1 in the same cycle -> VALID=0, next IMEM_ADDR=0040, ABCD never output.
- Wrap: PC=16'hFFFF holding a one-word instruction -> PC_OUT=0000, next IMEM_ADDR=0000.
- FETCH_INT_EN: INT=1 at PC=16'h0020, mem[1]=16'h0100 -> EPC=0020, INT_ACK pulses for one cycle, next IMEM_ADDR=0100.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Boots from a memory-held reset vector,
//            assembles one/two-word instructions and honours stall/flush.
//            Optional interrupt entry is enabled by defining FETCH_INT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VEC = '0,
    parameter logic [DATA_W-1:0] INT_VEC   = {{(DATA_W-1){1'b0}}, 1'b1}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] BR_TARGET,
    output logic [DATA_W-1:0] IMEM_ADDR,
    input  logic [DATA_W-1:0] IMEM_DATA,
    output logic [DATA_W-1:0] IR_OUT,
    output logic [DATA_W-1:0] IMM_OUT,
    output logic [DATA_W-1:0] PC_OUT,
    output logic              VALID
`ifdef FETCH_INT_EN
   ,input  logic              INT,
    output logic              INT_ACK,
    output logic [DATA_W-1:0] EPC
`endif
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_IMM   = 2'd2;
`ifdef FETCH_INT_EN
    localparam logic [1:0] S_INTV  = 2'd3;
`endif

    logic [1:0]        state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_inc;
    logic              two_word;

    // Wraps naturally at 2^DATA_W.
    assign pc_inc   = pc + DATA_W'(1);
    assign two_word = (IMEM_DATA[DATA_W-1 -: 2] == 2'b11);

    always_comb begin
        IMEM_ADDR = pc;
        case (state)
            S_BOOT:  IMEM_ADDR = RESET_VEC;
`ifdef FETCH_INT_EN
            S_INTV:  IMEM_ADDR = INT_VEC;
`endif
            default: IMEM_ADDR = pc;
        endcase
    end

`ifdef FETCH_INT_EN
    assign INT_ACK = (state == S_INTV);
`else
    logic unused_int_vec;
    assign unused_int_vec = ^INT_VEC;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_BOOT;
            pc      <= '0;
            IR_OUT  <= '0;
            IMM_OUT <= '0;
            PC_OUT  <= '0;
            VALID   <= 1'b0;
`ifdef FETCH_INT_EN
            EPC     <= '0;
`endif
        end else begin
            case (state)
                S_BOOT: begin
                    pc    <= IMEM_DATA;
                    VALID <= 1'b0;
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (FLUSH) begin
                        pc    <= BR_TARGET;
                        VALID <= 1'b0;
                    end else if (!STALL) begin
`ifdef FETCH_INT_EN
                        if (INT) begin
                            // Fetch of this cycle is dropped; pc resumes here.
                            EPC   <= pc;
                            VALID <= 1'b0;
                            state <= S_INTV;
                        end else
`endif
                        begin
                            IR_OUT <= IMEM_DATA;
                            pc     <= pc_inc;
                            PC_OUT <= pc_inc;
                            if (two_word) begin
                                VALID <= 1'b0;
                                state <= S_IMM;
                            end else begin
                                IMM_OUT <= '0;
                                VALID   <= 1'b1;
                            end
                        end
                    end
                end
                S_IMM: begin
                    if (FLUSH) begin
                        pc    <= BR_TARGET;
                        VALID <= 1'b0;
                        state <= S_FETCH;
                    end else if (!STALL) begin
                        IMM_OUT <= IMEM_DATA;
                        pc      <= pc_inc;
                        PC_OUT  <= pc_inc;
                        VALID   <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
`ifdef FETCH_INT_EN
                S_INTV: begin
                    pc    <= IMEM_DATA;
                    VALID <= 1'b0;
                    state <= S_FETCH;
                end
`endif
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Bench for fetch_unit: memory model, instruction scoreboard and directed
// reset/boot, two-word, stall, flush, wrap and (optional) interrupt scenarios.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic [15:0] BR_TARGET = 16'h0000;
    logic [15:0] IMEM_ADDR;
    logic [15:0] IMEM_DATA;
    logic [15:0] IR_OUT;
    logic [15:0] IMM_OUT;
    logic [15:0] PC_OUT;
    logic        VALID;
`ifdef FETCH_INT_EN
    logic        INT = 1'b0;
    logic        INT_ACK;
    logic [15:0] EPC;
`endif

    logic [15:0] mem [0:65535];
    assign IMEM_DATA = mem[IMEM_ADDR];

    fetch_unit #(
        .DATA_W    (16),
        .RESET_VEC (16'h0000),
        .INT_VEC   (16'h0001)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .STALL     (STALL),
        .FLUSH     (FLUSH),
        .BR_TARGET (BR_TARGET),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_DATA (IMEM_DATA),
        .IR_OUT    (IR_OUT),
        .IMM_OUT   (IMM_OUT),
        .PC_OUT    (PC_OUT),
        .VALID     (VALID)
`ifdef FETCH_INT_EN
       ,.INT       (INT),
        .INT_ACK   (INT_ACK),
        .EPC       (EPC)
`endif
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q [$];
    logic [47:0] exp_e;
    logic        stall_seen = 1'b0;
    logic [64:0] snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 64'(VALID), 64'd0);
        check({tag, "_ir"}, 64'(IR_OUT), 64'h0);
        check({tag, "_imm"}, 64'(IMM_OUT), 64'h0);
        check({tag, "_pcout"}, 64'(PC_OUT), 64'h0);
        check({tag, "_addr"}, 64'(IMEM_ADDR), 64'h0000);
    endtask

    always @(posedge CLK) stall_seen <= STALL;

    // Scoreboard: a fresh instruction appears on each unstalled edge with VALID high.
    always @(negedge CLK) begin
        if (!RST && VALID && !stall_seen) begin
            if (exp_q.size() == 0) begin
                check("spurious_instr_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_e = exp_q.pop_front();
                check("instr", {16'h0, IR_OUT, IMM_OUT, PC_OUT}, {16'h0, exp_e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h0010;
        mem[16'h0001] = 16'h0100;
        mem[16'h0010] = 16'h1234;
        mem[16'h0011] = 16'hC005;
        mem[16'h0012] = 16'hABCD;
        mem[16'h0013] = 16'h2222;
        mem[16'h0014] = 16'h3333;
        mem[16'h0015] = 16'h4444;
        mem[16'h0016] = 16'hC007;
        mem[16'h0017] = 16'hABCD;
        mem[16'h0040] = 16'h5555;
        mem[16'h0100] = 16'h7777;
        mem[16'hFFFF] = 16'h6666;

        #12;
        check_reset_vals("reset");

        @(negedge CLK);
        RST = 1'b0;
        exp_q.push_back({16'h1234, 16'h0000, 16'h0011});
        exp_q.push_back({16'hC005, 16'hABCD, 16'h0013});
        exp_q.push_back({16'h2222, 16'h0000, 16'h0014});
        tick(1);
        check("boot_valid", 64'(VALID), 64'd0);
        check("boot_addr", 64'(IMEM_ADDR), 64'h0010);
        tick(1);
        check("first_valid", 64'(VALID), 64'd1);
        check("fetch_addr", 64'(IMEM_ADDR), 64'h0011);
        tick(1);
        check("imm_wait_valid", 64'(VALID), 64'd0);
        check("imm_addr", 64'(IMEM_ADDR), 64'h0012);
        tick(2);

        snap = {IMEM_ADDR, IR_OUT, IMM_OUT, PC_OUT, VALID};
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_hold", 64'({IMEM_ADDR, IR_OUT, IMM_OUT, PC_OUT, VALID} != snap), 64'd0);
            check("stall_addr", 64'(IMEM_ADDR), 64'h0014);
        end
        STALL = 1'b0;
        exp_q.push_back({16'h3333, 16'h0000, 16'h0015});
        exp_q.push_back({16'h4444, 16'h0000, 16'h0016});
        tick(2);
        tick(1);
        check("imm2_addr", 64'(IMEM_ADDR), 64'h0017);

        FLUSH = 1'b1; STALL = 1'b1; BR_TARGET = 16'h0040;
        tick(1);
        FLUSH = 1'b0; STALL = 1'b0;
        check("flush_imm_valid", 64'(VALID), 64'd0);
        check("flush_imm_addr", 64'(IMEM_ADDR), 64'h0040);
        exp_q.push_back({16'h5555, 16'h0000, 16'h0041});
        tick(1);

        FLUSH = 1'b1; BR_TARGET = 16'hFFFF;
        tick(1);
        FLUSH = 1'b0;
        check("flush_fetch_valid", 64'(VALID), 64'd0);
        check("flush_fetch_addr", 64'(IMEM_ADDR), 64'hFFFF);
        exp_q.push_back({16'h6666, 16'h0000, 16'h0000});
        exp_q.push_back({16'h0010, 16'h0000, 16'h0001});
        tick(1);
        check("wrap_addr", 64'(IMEM_ADDR), 64'h0000);
        tick(1);

`ifdef FETCH_INT_EN
        FLUSH = 1'b1; BR_TARGET = 16'h0020;
        tick(1);
        FLUSH = 1'b0; INT = 1'b1;
        tick(1);
        INT = 1'b0;
        check("int_epc", 64'(EPC), 64'h0020);
        check("int_ack_hi", 64'(INT_ACK), 64'd1);
        check("int_valid", 64'(VALID), 64'd0);
        check("int_vec_addr", 64'(IMEM_ADDR), 64'h0001);
        tick(1);
        check("int_ack_lo", 64'(INT_ACK), 64'd0);
        check("int_handler_addr", 64'(IMEM_ADDR), 64'h0100);
        exp_q.push_back({16'h7777, 16'h0000, 16'h0101});
        tick(1);
`endif

        FLUSH = 1'b1; BR_TARGET = 16'h0011;
        tick(1);
        FLUSH = 1'b0;
        tick(1);
        check("pre_rst_addr", 64'(IMEM_ADDR), 64'h0012);
        #2 RST = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        exp_q.push_back({16'h1234, 16'h0000, 16'h0011});
        tick(3);

        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
